// File: rtl/aw_video_scanout_pkg.sv
// Shared constants and types for the Another World video scanout block.
// Geometry of the 2x2-doubled 320x200 window inside the 640x480 frame.
package aw_video_scanout_pkg;

  localparam int unsigned V_TOP      = 40;
  localparam int unsigned V_LINES    = 400;
  localparam int unsigned H_PIX      = 640;
  localparam int unsigned LINE_BYTES = 160;
  localparam int unsigned FB_AW      = 17;
  localparam int unsigned FB_OW      = 15;
  localparam int unsigned PAL_W      = 12;
  localparam int unsigned PIPE_LAT   = 3;

  typedef logic [PAL_W-1:0] color_t;
  typedef logic [3:0]       pal_idx_t;
  typedef logic [FB_OW-1:0] fb_off_t;

  function automatic logic in_window_rows(input logic [9:0] vpos);
    return (vpos >= 10'(V_TOP)) && (vpos < 10'(V_TOP + V_LINES));
  endfunction

endpackage

// File: rtl/aw_video_scanout_if.sv
// Framebuffer read port: registered address/strobe out, data back one clock later.
interface aw_video_scanout_if;

  logic [aw_video_scanout_pkg::FB_AW-1:0] fb_addr;
  logic                                   fb_rd;
  logic [7:0]                             fb_data;

  modport master (output fb_addr, output fb_rd, input fb_data);
  modport slave  (input fb_addr, input fb_rd, output fb_data);

endinterface

// File: rtl/aw_palette_regfile.sv
// 16-entry colour palette: one synchronous write port, one combinational read port.
// A read of an entry written on the same edge returns the previous contents.
module aw_palette_regfile
  import aw_video_scanout_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     we,
  input  pal_idx_t waddr,
  input  color_t   wdata,
  input  pal_idx_t raddr,
  output color_t   rdata
);

  logic [15:0][PAL_W-1:0] pal_q;
  logic [15:0][PAL_W-1:0] pal_d;

  always_comb begin
    pal_d = pal_q;
    if (we) pal_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pal_q <= '0;
    else        pal_q <= pal_d;
  end

  assign rdata = pal_q[raddr];

endmodule

// File: rtl/aw_video_scanout.sv
// Scans the 320x200 4bpp framebuffer out as a 2x2-doubled 640x400 window centred in 640x480,
// through the palette, with hsync/vsync delayed to match the three-stage pixel pipeline.
module aw_video_scanout
  import aw_video_scanout_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          hpos,
  input  logic [9:0]          vpos,
  input  logic                display_on,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic [1:0]          fb_page,
  aw_video_scanout_if.master  fb,
  input  logic                pal_we,
  input  pal_idx_t            pal_idx,
  input  color_t              pal_color,
  output color_t              rgb444,
  output logic [2:0]          rgb,
  output logic                hsync,
  output logic                vsync
);

  logic               line_start, frame_start, row_win, win;
  logic [9:0]         vdelta;

  logic [1:0]         page_q, page_d;
  fb_off_t            line_base_q, line_base_d;
  logic               armed_q, armed_d;

  logic [FB_AW-1:0]   fb_addr_q, fb_addr_d;
  logic               fb_rd_q, fb_rd_d;
  logic               win_d1_q, win_d1_d;
  logic               nib_d1_q, nib_d1_d;
  pal_idx_t           idx_d2_q, idx_d2_d;
  logic               win_d2_q, win_d2_d;
  color_t             rgb444_q, rgb444_d;
  color_t             pal_rdata;

  logic [PIPE_LAT-1:0] hs_pipe_q, hs_pipe_d;
  logic [PIPE_LAT-1:0] vs_pipe_q, vs_pipe_d;

  always_comb begin
    line_start  = (hpos == '0);
    frame_start = line_start && (vpos == '0);
    row_win     = in_window_rows(vpos);
    vdelta      = vpos - 10'(V_TOP);
    // After reset the block stays dark until a line begins, so no partial line is shown.
    win         = display_on && row_win && (hpos < 10'(H_PIX)) && (armed_q || line_start);
    armed_d     = armed_q || line_start;

    page_d      = frame_start ? fb_page : page_q;

    line_base_d = line_base_q;
    if (frame_start)
      line_base_d = '0;
    else if (row_win && (hpos == 10'(H_PIX)) && vdelta[0])
      line_base_d = line_base_q + fb_off_t'(LINE_BYTES);
  end

  // Pixel pipeline: S0 address, S1 nibble select, S2 palette lookup.
  always_comb begin
    fb_addr_d = win ? {page_q, line_base_q + fb_off_t'(hpos[9:2])} : fb_addr_q;
    fb_rd_d   = win;
    win_d1_d  = win;
    nib_d1_d  = hpos[1];

    idx_d2_d  = nib_d1_q ? fb.fb_data[3:0] : fb.fb_data[7:4];
    win_d2_d  = win_d1_q;

    rgb444_d  = win_d2_q ? pal_rdata : '0;

    hs_pipe_d = {hs_pipe_q[PIPE_LAT-2:0], hsync_in};
    vs_pipe_d = {vs_pipe_q[PIPE_LAT-2:0], vsync_in};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      page_q      <= '0;
      line_base_q <= '0;
      armed_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_rd_q     <= 1'b0;
      win_d1_q    <= 1'b0;
      nib_d1_q    <= 1'b0;
      idx_d2_q    <= '0;
      win_d2_q    <= 1'b0;
      rgb444_q    <= '0;
      hs_pipe_q   <= '0;
      vs_pipe_q   <= '0;
    end else begin
      page_q      <= page_d;
      line_base_q <= line_base_d;
      armed_q     <= armed_d;
      fb_addr_q   <= fb_addr_d;
      fb_rd_q     <= fb_rd_d;
      win_d1_q    <= win_d1_d;
      nib_d1_q    <= nib_d1_d;
      idx_d2_q    <= idx_d2_d;
      win_d2_q    <= win_d2_d;
      rgb444_q    <= rgb444_d;
      hs_pipe_q   <= hs_pipe_d;
      vs_pipe_q   <= vs_pipe_d;
    end
  end

  aw_palette_regfile u_pal (
    .clk   (clk),
    .rst_n (reset),
    .we    (pal_we),
    .waddr (pal_idx),
    .wdata (pal_color),
    .raddr (idx_d2_q),
    .rdata (pal_rdata)
  );

  assign fb.fb_addr = fb_addr_q;
  assign fb.fb_rd   = fb_rd_q;
  assign rgb444     = rgb444_q;
  assign rgb        = {rgb444_q[3], rgb444_q[7], rgb444_q[11]};
  assign hsync      = hs_pipe_q[PIPE_LAT-1];
  assign vsync      = vs_pipe_q[PIPE_LAT-1];

endmodule

// File: tb/tb_aw_video_scanout.sv
// Directed bench for aw_video_scanout: drives hpos/vpos directly and models the framebuffer.
module tb_aw_video_scanout;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hpos, vpos;
  logic        display_on, hsync_in, vsync_in;
  logic [1:0]  fb_page;
  logic        pal_we;
  logic [3:0]  pal_idx;
  logic [11:0] pal_color;
  logic [11:0] rgb444;
  logic [2:0]  rgb;
  logic        hsync, vsync;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [0:131071];
  logic [1:0] hist [$];

  aw_video_scanout_if fb_if ();

  assign fb_if.fb_data = fb_if.fb_rd ? mem[fb_if.fb_addr] : 8'h00;

  aw_video_scanout dut (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .fb_page    (fb_page),
    .fb         (fb_if),
    .pal_we     (pal_we),
    .pal_idx    (pal_idx),
    .pal_color  (pal_color),
    .rgb444     (rgb444),
    .rgb        (rgb),
    .hsync      (hsync),
    .vsync      (vsync)
  );

  always #5 clk = ~clk;

  task automatic drive(input int h, input int v, input logic d, input logic hs, input logic vs);
    hpos       = 10'(h);
    vpos       = 10'(v);
    display_on = d;
    hsync_in   = hs;
    vsync_in   = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pal_wr(input logic [3:0] idx, input logic [11:0] col);
    pal_we    = 1'b1;
    pal_idx   = idx;
    pal_color = col;
    drive(300, 60, 1'b1, 1'b0, 1'b0);
    pal_we    = 1'b0;
  endtask

  initial begin
    reset = 1'b0; hpos = '0; vpos = '0; display_on = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; fb_page = 2'd0;
    pal_we = 1'b0; pal_idx = '0; pal_color = '0;
    for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
    mem[0]          = 8'h3C;
    mem[17'h100A2]  = 8'hA5;
    mem[17'h100A3]  = 8'h33;
    #1;

    // Held in reset while the inputs sit mid-window with syncs high
    repeat (4) drive(100, 50, 1'b1, 1'b1, 1'b1);
    chk("rst_rgb444", 32'(rgb444), 32'h0);
    chk("rst_rgb",    32'(rgb),    32'h0);
    chk("rst_hsync",  32'(hsync),  32'h0);
    chk("rst_vsync",  32'(vsync),  32'h0);
    chk("rst_fb_rd",  32'(fb_if.fb_rd),   32'h0);
    chk("rst_fb_addr",32'(fb_if.fb_addr), 32'h0);

    // Release mid-line: stays black for the rest of this line
    reset = 1'b1;
    pal_wr(4'd0,  12'h777);
    pal_wr(4'd3,  12'h123);
    pal_wr(4'd12, 12'h456);
    pal_wr(4'd10, 12'hF00);
    pal_wr(4'd5,  12'h00F);
    chk("post_rst_black", 32'(rgb444), 32'h0);

    // First window line after reset
    drive(0, 40, 1'b1, 1'b0, 1'b0);
    chk("line40_addr", 32'(fb_if.fb_addr), 32'h0);
    chk("line40_rd",   32'(fb_if.fb_rd),   32'h1);
    drive(1, 40, 1'b1, 1'b0, 1'b0);
    drive(2, 40, 1'b1, 1'b0, 1'b0);
    chk("first_px0", 32'(rgb444), 32'h123);
    drive(3, 40, 1'b1, 1'b0, 1'b0);
    chk("first_px1", 32'(rgb444), 32'h123);
    drive(4, 40, 1'b1, 1'b0, 1'b0);
    chk("first_px2", 32'(rgb444), 32'h456);
    repeat (3) drive(700, 40, 1'b0, 1'b0, 1'b0);

    // Frame start with page 2, then advance to source line 1
    fb_page = 2'd2;
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    drive(640, 40, 1'b1, 1'b0, 1'b0);
    drive(640, 41, 1'b1, 1'b0, 1'b0);
    drive(640, 42, 1'b1, 1'b0, 1'b0);
    chk("h640_rd", 32'(fb_if.fb_rd), 32'h0);
    drive(641, 42, 1'b1, 1'b0, 1'b0);
    drive(642, 42, 1'b1, 1'b0, 1'b0);
    chk("h640_rgb", 32'(rgb444), 32'h0);

    // Address map and nibble doubling
    drive(8, 43, 1'b1, 1'b0, 1'b0);
    chk("addr_map", 32'(fb_if.fb_addr), 32'h100A2);
    chk("addr_rd",  32'(fb_if.fb_rd),   32'h1);
    drive(9, 43, 1'b1, 1'b0, 1'b0);
    drive(10, 43, 1'b1, 1'b0, 1'b0);
    chk("px_h8",     32'(rgb444), 32'hF00);
    chk("px_h8_rgb", 32'(rgb),    32'h1);
    drive(11, 43, 1'b1, 1'b0, 1'b0);
    chk("px_h9", 32'(rgb444), 32'hF00);
    drive(12, 43, 1'b1, 1'b0, 1'b0);
    chk("px_h10",     32'(rgb444), 32'h00F);
    chk("px_h10_rgb", 32'(rgb),    32'h4);
    drive(13, 43, 1'b1, 1'b0, 1'b0);
    chk("px_h11", 32'(rgb444), 32'h00F);

    // Palette write coinciding with the S2 read of the same entry
    pal_we = 1'b1; pal_idx = 4'd3; pal_color = 12'h0F0;
    drive(14, 43, 1'b1, 1'b0, 1'b0);
    pal_we = 1'b0;
    chk("haz_old", 32'(rgb444), 32'h123);
    drive(15, 43, 1'b1, 1'b0, 1'b0);
    chk("haz_new",     32'(rgb444), 32'h0F0);
    chk("haz_new_rgb", 32'(rgb),    32'h2);
    repeat (3) drive(700, 43, 1'b0, 1'b0, 1'b0);

    // Band above the window
    drive(8, 39, 1'b1, 1'b0, 1'b0);
    chk("v39_rd", 32'(fb_if.fb_rd), 32'h0);
    drive(9, 39, 1'b1, 1'b0, 1'b0);
    drive(10, 39, 1'b1, 1'b0, 1'b0);
    chk("v39_rgb", 32'(rgb444), 32'h0);

    // Walk the remaining odd lines so the last source line base is reached
    for (int v = 43; v <= 437; v += 2) drive(640, v, 1'b1, 1'b0, 1'b0);
    drive(639, 439, 1'b1, 1'b0, 1'b0);
    chk("last_addr", 32'(fb_if.fb_addr), 32'h17CFF);
    chk("last_rd",   32'(fb_if.fb_rd),   32'h1);

    // Band below the window
    drive(8, 440, 1'b1, 1'b0, 1'b0);
    chk("v440_rd", 32'(fb_if.fb_rd), 32'h0);
    drive(9, 440, 1'b1, 1'b0, 1'b0);
    drive(10, 440, 1'b1, 1'b0, 1'b0);
    chk("v440_rgb", 32'(rgb444), 32'h0);

    // Page change mid-frame takes effect only at the next frame start
    fb_page = 2'd1;
    drive(8, 100, 1'b1, 1'b0, 1'b0);
    chk("page_hold", 32'(fb_if.fb_addr >> 15), 32'h2);
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    drive(8, 40, 1'b1, 1'b0, 1'b0);
    chk("page_new", 32'(fb_if.fb_addr), 32'h08002);

    // Sync delay line
    for (int i = 0; i < 64; i++) begin
      logic [1:0] s;
      s = 2'($urandom);
      hist.push_back(s);
      drive(700, 0, 1'b0, s[1], s[0]);
      if (i >= 2) chk("sync_delay", 32'({hsync, vsync}), 32'(hist[i-2]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
